// File: rtl/param_shift_reg_if.sv
// Control, data and handshake bundle for param_shift_reg.
// The clock and the reset stay plain ports on the module.
interface param_shift_reg_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AW = $clog2(WIDTH + 1);

  logic             preset;
  logic             clear;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;

  modport master (
    output preset, clear, en, mode, d, sin_l, sin_r, start, amt,
    input  q, sout_msb, sout_lsb, busy, done
  );

  modport slave (
    input  preset, clear, en, mode, d, sin_l, sin_r, start, amt,
    output q, sout_msb, sout_lsb, busy, done
  );
endinterface

// File: rtl/param_shift_reg.sv
// WIDTH-bit register with preset/clear, single-cycle load/shift/rotate modes
// and a multi-cycle shift-by-N sequencer with a busy/done handshake.
module param_shift_reg #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input logic            clk,
  input logic            reset,
  param_shift_reg_if.slave bus
);
  localparam int unsigned AW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_HOLD2 = 3'b111
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d, op_in;
  logic [AW-1:0]    cnt_q, cnt_d, amt_clamped;
  logic [WIDTH-1:0] q_q, q_d;

  function automatic logic [WIDTH-1:0] shift_op(input op_e op, input logic [WIDTH-1:0] v,
                                                input logic sl, input logic sr);
    logic [WIDTH-1:0] r;
    r = v;
    case (op)
      OP_SHL:  r = {v[WIDTH-2:0], sr};
      OP_SHR:  r = {sl, v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[WIDTH-1:1]};
      OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign op_in       = op_e'(bus.mode);
  // amt is wide enough to hold WIDTH, so the compare never wraps
  assign amt_clamped = (bus.amt > AW'(WIDTH)) ? AW'(WIDTH) : bus.amt;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    if (bus.preset) begin
      q_d     = PRESET_VAL;
      state_d = IDLE;
    end else if (bus.clear) begin
      q_d     = '0;
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      q_d = shift_op(op_q, q_q, bus.sin_l, bus.sin_r);
      if (cnt_q == AW'(1)) begin
        cnt_d   = '0;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q - AW'(1);
      end
    end else if (bus.start) begin
      op_d  = op_in;
      cnt_d = amt_clamped;
      if ((op_in inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR}) && (amt_clamped != '0))
        state_d = SHIFT;
      else
        state_d = DONE;
    end else begin
      state_d = IDLE;
      if (bus.en)
        q_d = (op_in == OP_LOAD) ? bus.d : shift_op(op_in, q_q, bus.sin_l, bus.sin_r);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      q_q     <= RESET_VAL;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.sout_msb = q_q[WIDTH-1];
  assign bus.sout_lsb = q_q[0];
  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_param_shift_reg.sv
// Directed-vector bench for param_shift_reg at WIDTH=8 with hand-computed
// expected values; inputs change 1 time unit after each rising edge.
module tb_param_shift_reg;
  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;

  param_shift_reg_if #(.WIDTH(8)) bus ();

  param_shift_reg #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    bus.en   = 1'b1;
    bus.mode = 3'b001;
    bus.d    = v;
    step();
    bus.en   = 1'b0;
  endtask

  task automatic start_seq(input logic [2:0] m, input logic [3:0] a);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.amt   = a;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset      = 1'b1;
    bus.preset = 1'b1;
    bus.clear  = 1'b1;
    bus.start  = 1'b1;
    bus.en     = 1'b1;
    bus.mode   = 3'b001;
    bus.d      = 8'hAA;
    bus.sin_l  = 1'b0;
    bus.sin_r  = 1'b0;
    bus.amt    = 4'd3;

    // 1: reset dominates everything, then preset beats clear
    step();
    check("rst_q", bus.q, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.en    = 1'b0;
    step();
    check("preset_over_clear", bus.q, 8'hFF);
    bus.preset = 1'b0;
    step();
    check("clear_only", bus.q, 8'h00);
    bus.clear = 1'b0;

    // 2: single-cycle modes
    load(8'hA5);
    check("load", bus.q, 8'hA5);
    bus.en = 1'b1; bus.mode = 3'b100; step(); bus.en = 1'b0;
    check("rol", bus.q, 8'h4B);
    load(8'hA5);
    bus.en = 1'b1; bus.mode = 3'b101; step(); bus.en = 1'b0;
    check("ror", bus.q, 8'hD2);
    load(8'hA5);
    bus.en = 1'b1; bus.mode = 3'b011; bus.sin_l = 1'b0; step(); bus.en = 1'b0;
    check("shr", bus.q, 8'h52);
    load(8'hA5);
    bus.en = 1'b1; bus.mode = 3'b110; step(); bus.en = 1'b0;
    check("asr", bus.q, 8'hD2);
    load(8'hA5);
    bus.en = 1'b1; bus.mode = 3'b010; bus.sin_r = 1'b1; step(); bus.en = 1'b0;
    check("shl", bus.q, 8'h4B);
    bus.mode = 3'b100; step();
    check("en0_hold", bus.q, 8'h4B);
    check("sout_msb", bus.sout_msb, 1'b0);
    check("sout_lsb", bus.sout_lsb, 1'b1);
    bus.en = 1'b1; bus.mode = 3'b111; step(); bus.en = 1'b0;
    check("mode111_hold", bus.q, 8'h4B);
    bus.sin_r = 1'b0;

    // 3: rol by 3 sequence
    load(8'h81);
    start_seq(3'b100, 4'd3);
    check("seq_e0_q", bus.q, 8'h81);
    check("seq_e0_busy", bus.busy, 1'b1);
    step();
    check("seq_e1_q", bus.q, 8'h03);
    check("seq_e1_busy", bus.busy, 1'b1);
    step();
    check("seq_e2_q", bus.q, 8'h06);
    step();
    check("seq_e3_q", bus.q, 8'h0C);
    check("seq_e3_busy", bus.busy, 1'b0);
    check("seq_e3_done", bus.done, 1'b1);
    step();
    check("seq_done_pulse", bus.done, 1'b0);
    check("seq_idle_q", bus.q, 8'h0C);

    // 4: shl by 8 aborted by clear; start while busy ignored
    load(8'hFF);
    bus.sin_r = 1'b0;
    start_seq(3'b010, 4'd8);
    check("abort_e0_busy", bus.busy, 1'b1);
    step();
    check("abort_e1_q", bus.q, 8'hFE);
    bus.start = 1'b1; bus.mode = 3'b100; bus.amt = 4'd1;
    step();
    check("abort_e2_q", bus.q, 8'hFC);
    step();
    bus.start = 1'b0;
    check("abort_busy_start_ign", bus.q, 8'hF8);
    check("abort_e3_busy", bus.busy, 1'b1);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    check("abort_clear_q", bus.q, 8'h00);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_no_done", bus.done, 1'b0);
    step();
    check("abort_no_done_late", bus.done, 1'b0);

    // 5: clamp amt=12 to 8, then zero-length sequences
    load(8'h3C);
    start_seq(3'b100, 4'd12);
    for (int unsigned i = 1; i < 8; i++) step();
    check("clamp_e7_busy", bus.busy, 1'b1);
    check("clamp_e7_q", bus.q, 8'h1E);
    step();
    check("clamp_e8_q", bus.q, 8'h3C);
    check("clamp_e8_done", bus.done, 1'b1);
    check("clamp_e8_busy", bus.busy, 1'b0);
    step();
    start_seq(3'b100, 4'd0);
    check("amt0_done", bus.done, 1'b1);
    check("amt0_busy", bus.busy, 1'b0);
    check("amt0_q", bus.q, 8'h3C);
    step();
    check("amt0_pulse_end", bus.done, 1'b0);
    bus.d = 8'h00;
    start_seq(3'b001, 4'd3);
    check("load_mode_done", bus.done, 1'b1);
    check("load_mode_q", bus.q, 8'h3C);
    step();

    // 6: back-to-back start on DONE cycle, then reset mid-sequence
    start_seq(3'b100, 4'd1);
    check("b2b_e0_busy", bus.busy, 1'b1);
    bus.sin_l = 1'b1;
    bus.start = 1'b1; bus.mode = 3'b011; bus.amt = 4'd2;
    step();
    check("b2b_first_done", bus.done, 1'b1);
    check("b2b_first_q", bus.q, 8'h78);
    step();
    bus.start = 1'b0;
    check("b2b_second_busy", bus.busy, 1'b1);
    check("b2b_second_nodone", bus.done, 1'b0);
    step();
    check("b2b_e1_q", bus.q, 8'hBC);
    step();
    check("b2b_e2_q", bus.q, 8'hDE);
    check("b2b_e2_done", bus.done, 1'b1);
    step();
    start_seq(3'b100, 4'd5);
    step();
    check("rst_mid_e1_busy", bus.busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_q", bus.q, 8'h00);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_done", bus.done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
